pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state encoding, counter widths and default timing for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int COUNT_W                 = 8;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 74250;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    logic [COUNT_W-1:0] result;
    if (value == {COUNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + COUNT_W'(1'b1);
    end
    return result;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the local clock domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_meta;

  // Shift the async level through two flops; cleared while the block is in reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 2'b00;
    end else begin
      r_meta <= {r_meta[0], i_d};
    end
  end

  assign o_q = r_meta[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings a PLL out of reset, waits for a stable lock, then releases the PLL-domain
// reset; retries on lock timeout and restarts on lock loss or request.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               reset_req,
  output logic               pll_rst,
  output logic               core_reset_n,
  output logic               pll_ready,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] lock_loss_count,
  output logic [COUNT_W-1:0] retry_count
);

  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic               w_locked_s;
  seq_state_e         w_next_state;
  logic               w_loss_inc;
  logic               w_retry_inc;
  logic               w_cnt_clr;

  seq_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pll_rst;
  logic               r_core_reset_n;
  logic               r_pll_ready;
  logic [COUNT_W-1:0] r_lock_loss;
  logic [COUNT_W-1:0] r_retry;

  sync_2ff u_lock_sync (
    .i_clk   (clk_74a),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  // Transition decision; reset_req wins, but a coincident lock drop in RUN is still counted.
  always_comb begin
    w_next_state = r_state;
    w_loss_inc   = 1'b0;
    w_retry_inc  = 1'b0;
    if (reset_req) begin
      w_next_state = ST_PLL_RST;
      w_loss_inc   = (r_state == ST_RUN) && !w_locked_s;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == RST_LAST) begin
            w_next_state = ST_WAIT_LOCK;
          end else begin
            w_next_state = ST_PLL_RST;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next_state = ST_STABLE;
          end else if (r_cnt == TMO_LAST) begin
            w_next_state = ST_PLL_RST;
            w_retry_inc  = 1'b1;
          end else begin
            w_next_state = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            w_next_state = ST_WAIT_LOCK;
          end else if (r_cnt == STB_LAST) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_state = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_next_state = ST_PLL_RST;
            w_loss_inc   = 1'b1;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        default: begin
          w_next_state = ST_PLL_RST;
        end
      endcase
    end
  end

  assign w_cnt_clr = reset_req || (w_next_state != r_state);

  // State, dwell counter, statistics and outputs; outputs follow the state being entered.
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_state        <= ST_PLL_RST;
      r_cnt          <= {CNT_W{1'b0}};
      r_pll_rst      <= 1'b1;
      r_core_reset_n <= 1'b0;
      r_pll_ready    <= 1'b0;
      r_lock_loss    <= {COUNT_W{1'b0}};
      r_retry        <= {COUNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_cnt_clr) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_state != ST_RUN) begin
        r_cnt <= r_cnt + CNT_W'(1'b1);
      end else begin
        r_cnt <= r_cnt;
      end
      r_pll_rst      <= (w_next_state == ST_PLL_RST);
      r_core_reset_n <= (w_next_state == ST_RUN);
      r_pll_ready    <= (w_next_state == ST_RUN);
      if (w_loss_inc) begin
        r_lock_loss <= sat_inc(r_lock_loss);
      end else begin
        r_lock_loss <= r_lock_loss;
      end
      if (w_retry_inc) begin
        r_retry <= sat_inc(r_retry);
      end else begin
        r_retry <= r_retry;
      end
    end
  end

  assign state           = r_state;
  assign pll_rst         = r_pll_rst;
  assign core_reset_n    = r_core_reset_n;
  assign pll_ready       = r_pll_ready;
  assign lock_loss_count = r_lock_loss;
  assign retry_count     = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios with arithmetic
// expectations plus a randomized run against a cycle-level reference model.
module tb_pll_reset_sequencer;

  localparam int RST_N = 4;
  localparam int STB   = 8;
  localparam int TMO   = 32;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       reset_req;
  logic       pll_rst;
  logic       core_reset_n;
  logic       pll_ready;
  logic [1:0] state;
  logic [7:0] lock_loss_count;
  logic [7:0] retry_count;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (RST_N),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_74a         (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .reset_req       (reset_req),
    .pll_rst         (pll_rst),
    .core_reset_n    (core_reset_n),
    .pll_ready       (pll_ready),
    .state           (state),
    .lock_loss_count (lock_loss_count),
    .retry_count     (retry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0..3 = reset/wait/stable/run, age = cycles already spent in phase.
  int m_phase = 0;
  int m_age   = 0;
  int m_loss  = 0;
  int m_retry = 0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;
  int m_np;

  function automatic int next_phase(input int ph, input int age, input bit ls, input bit req);
    if (req) return 0;
    case (ph)
      0:       return (age + 1 >= RST_N) ? 1 : 0;
      1:       return ls ? 2 : ((age + 1 >= TMO) ? 0 : 1);
      2:       return !ls ? 1 : ((age + 1 >= STB) ? 3 : 2);
      default: return ls ? 3 : 0;
    endcase
  endfunction

  always_comb m_np = next_phase(m_phase, m_age, m_s2, reset_req);

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase <= 0; m_age <= 0; m_loss <= 0; m_retry <= 0; m_s1 <= 1'b0; m_s2 <= 1'b0;
    end else begin
      m_s1    <= pll_locked;
      m_s2    <= m_s1;
      m_phase <= m_np;
      m_age   <= (reset_req || m_np != m_phase) ? 0 : m_age + 1;
      if (m_phase == 3 && !m_s2 && m_loss < 255) m_loss <= m_loss + 1;
      if (!reset_req && m_phase == 1 && !m_s2 && m_age + 1 >= TMO && m_retry < 255)
        m_retry <= m_retry + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit locked);
    reset_n = 1'b0; reset_req = 1'b0; pll_locked = locked;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, output int cycles, output bit ok);
    ok = 1'b0; cycles = 0;
    while (cycles < budget && !ok) begin
      tick();
      cycles++;
      if (state === st) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reset_req = 1'b0; pll_locked = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    n_checks++; if (core_reset_n !== 1'b0 || pll_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_core got core_reset_n=%b pll_ready=%b want 0/0", core_reset_n, pll_ready); end
    n_checks++; if (lock_loss_count !== 8'd0 || retry_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", lock_loss_count, retry_count); end
  endtask

  task automatic test_nominal();
    logic [1:0] exp_st;
    do_reset(1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_st = (k <= RST_N - 1) ? 2'd0 : 2'd1;
      n_checks++; if (pll_rst !== (k <= RST_N - 1)) begin
        n_fail++; $display("FAIL nominal_pll_rst k=%0d got %b want %b", k, pll_rst, (k <= RST_N - 1)); end
      n_checks++; if (state !== exp_st) begin
        n_fail++; $display("FAIL nominal_state_pre k=%0d got %0d want %0d", k, state, exp_st); end
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 2 + 1 + STB; k++) begin
      tick();
      exp_st = (k <= 2) ? 2'd1 : ((k < 2 + 1 + STB) ? 2'd2 : 2'd3);
      n_checks++; if (state !== exp_st) begin
        n_fail++; $display("FAIL nominal_state k=%0d got %0d want %0d", k, state, exp_st); end
      n_checks++; if (pll_ready !== (k == 2 + 1 + STB)) begin
        n_fail++; $display("FAIL nominal_ready k=%0d got %b want %b", k, pll_ready, (k == 2 + 1 + STB)); end
    end
    n_checks++; if (core_reset_n !== 1'b1 || pll_rst !== 1'b0) begin
      n_fail++; $display("FAIL nominal_run_outs got core_reset_n=%b pll_rst=%b want 1/0", core_reset_n, pll_rst); end
    n_checks++; if (lock_loss_count !== 8'd0 || retry_count !== 8'd0) begin
      n_fail++; $display("FAIL nominal_counts got %0d/%0d want 0/0", lock_loss_count, retry_count); end
  endtask

  task automatic test_timeout();
    int c;
    logic [1:0] exp_st;
    do_reset(1'b0);
    for (int t = 1; t <= 3 * (TMO + RST_N) + 2; t++) begin
      tick();
      c = t + 1;
      exp_st = (((c - 1) % (TMO + RST_N)) < RST_N) ? 2'd0 : 2'd1;
      n_checks++; if (state !== exp_st || retry_count !== 8'((c - 1) / (TMO + RST_N))) begin
        n_fail++; $display("FAIL timeout t=%0d got state=%0d retry=%0d want %0d/%0d",
                           t, state, retry_count, exp_st, (c - 1) / (TMO + RST_N)); end
      n_checks++; if (core_reset_n !== 1'b0) begin
        n_fail++; $display("FAIL timeout_core t=%0d got %b want 0", t, core_reset_n); end
    end
  endtask

  task automatic test_glitch();
    int cyc; bit ok;
    logic [1:0] exp_st;
    do_reset(1'b1);
    wait_state(2'd2, 40, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL glitch_reach_stable got timeout want state 2"); end
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) pll_locked = 1'b0;
      if (k == 5) pll_locked = 1'b1;
      tick();
      exp_st = (k <= 5) ? 2'd2 : ((k == 6) ? 2'd1 : ((k <= 14) ? 2'd2 : 2'd3));
      n_checks++; if (state !== exp_st) begin
        n_fail++; $display("FAIL glitch_state k=%0d got %0d want %0d", k, state, exp_st); end
    end
  endtask

  task automatic test_loss();
    int cyc; bit ok;
    do_reset(1'b1);
    wait_state(2'd3, 60, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL loss_reach_run got timeout want state 3"); end
    pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (core_reset_n !== (k < 3) || pll_ready !== (k < 3)) begin
        n_fail++; $display("FAIL loss_release k=%0d got core_reset_n=%b pll_ready=%b want %b",
                           k, core_reset_n, pll_ready, (k < 3)); end
    end
    n_checks++; if (pll_rst !== 1'b1 || lock_loss_count !== 8'd1) begin
      n_fail++; $display("FAIL loss_first got pll_rst=%b count=%0d want 1/1", pll_rst, lock_loss_count); end
    for (int n = 2; n <= 300; n++) begin
      pll_locked = 1'b1;
      wait_state(2'd3, 60, cyc, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL loss_rerun n=%0d got timeout want state 3", n); break; end
      pll_locked = 1'b0;
      wait_state(2'd0, 10, cyc, ok);
      n_checks++; if (!ok || lock_loss_count !== 8'((n > 255) ? 255 : n)) begin
        n_fail++; $display("FAIL loss_count n=%0d got %0d want %0d", n, lock_loss_count, (n > 255) ? 255 : n); end
    end
  endtask

  task automatic test_reset_in_run();
    int cyc; bit ok;
    pll_locked = 1'b1;
    wait_state(2'd3, 60, cyc, ok);
    n_checks++; if (!ok || lock_loss_count !== 8'd255) begin
      n_fail++; $display("FAIL rstrun_pre got ok=%b count=%0d want 1/255", ok, lock_loss_count); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++; if (state !== 2'd0 || pll_rst !== 1'b1 || core_reset_n !== 1'b0 || pll_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstrun_outs got st=%0d rst=%b core=%b rdy=%b want 0/1/0/0",
                         state, pll_rst, core_reset_n, pll_ready); end
    n_checks++; if (lock_loss_count !== 8'd0 || retry_count !== 8'd0) begin
      n_fail++; $display("FAIL rstrun_counts got %0d/%0d want 0/0", lock_loss_count, retry_count); end
  endtask

  task automatic test_reset_req();
    int cyc; bit ok;
    do_reset(1'b1);
    wait_state(2'd2, 40, cyc, ok);
    tick(); tick();
    reset_req = 1'b1; tick(); reset_req = 1'b0;
    n_checks++; if (!ok || state !== 2'd0 || pll_rst !== 1'b1 || lock_loss_count !== 8'd0) begin
      n_fail++; $display("FAIL req_stable got st=%0d rst=%b loss=%0d want 0/1/0", state, pll_rst, lock_loss_count); end
    for (int k = 1; k <= RST_N; k++) begin
      tick();
      n_checks++; if (state !== ((k < RST_N) ? 2'd0 : 2'd1)) begin
        n_fail++; $display("FAIL req_hold k=%0d got %0d want %0d", k, state, (k < RST_N) ? 0 : 1); end
    end
    wait_state(2'd3, 60, cyc, ok);
    reset_req = 1'b1; tick(); reset_req = 1'b0;
    n_checks++; if (!ok || state !== 2'd0 || core_reset_n !== 1'b0 || lock_loss_count !== 8'd0) begin
      n_fail++; $display("FAIL req_run got st=%0d core=%b loss=%0d want 0/0/0", state, core_reset_n, lock_loss_count); end
    wait_state(2'd3, 60, cyc, ok);
    pll_locked = 1'b0;
    tick(); tick();
    n_checks++; if (!ok || state !== 2'd3) begin
      n_fail++; $display("FAIL req_coinc_pre got st=%0d want 3", state); end
    reset_req = 1'b1; tick(); reset_req = 1'b0;
    n_checks++; if (state !== 2'd0 || lock_loss_count !== 8'd1) begin
      n_fail++; $display("FAIL req_coinc got st=%0d loss=%0d want 0/1", state, lock_loss_count); end
    pll_locked = 1'b1;
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) pll_locked = ~pll_locked;
      reset_req = ($urandom_range(0, 149) == 0);
      reset_n   = ($urandom_range(0, 799) != 0);
      tick();
      n_checks++;
      if (int'(state) !== m_phase || pll_rst !== (m_phase == 0) || core_reset_n !== (m_phase == 3) ||
          pll_ready !== (m_phase == 3) || int'(lock_loss_count) !== m_loss || int'(retry_count) !== m_retry) begin
        n_fail++;
        $display("FAIL random i=%0d got st=%0d rst=%b core=%b rdy=%b loss=%0d retry=%0d want st=%0d loss=%0d retry=%0d",
                 i, state, pll_rst, core_reset_n, pll_ready, lock_loss_count, retry_count, m_phase, m_loss, m_retry);
      end
    end
    reset_n = 1'b1; reset_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; reset_req = 1'b0; pll_locked = 1'b0;
    test_reset();
    test_nominal();
    test_timeout();
    test_glitch();
    test_reset_req();
    test_loss();
    test_reset_in_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
